ber_checker: RTL and testbench

Bit-error-rate checker that sits directly downstream of the receive chain's convolutional decoder. It compares each decoded bit against the transmitter's reference m-sequence bit, and it finds the unknown pipeline latency between the two automatically with a delay-tap search. Once locked, it accumulates bit and error counts and per-window error statistics for display or readout. It is the closing stage of the loopback link and reports measurable error rates with the channel error injection on or off.

---
 rtl/ber_checker.sv | 148 ++++++++++++++
 tb/tb_ber_checker.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ber_checker.sv
// Bit-error-rate checker: finds the rx-vs-reference latency by delay-tap search, then counts bits and errors.
// Latency: each output is registered and reflects a bit_en cycle on the next rising clk edge.
// Backpressure: none. One rx/ref bit pair is consumed on every bit_en-high cycle, at any spacing.
//
// Ports:
//   clk, reset (async, active-low)
//   bit_en, rx_bit, ref_bit   : strobed decoded bit and reference m-sequence bit
//   clear                     : synchronous zero of bit_cnt/err_cnt (wins over a same-cycle bit_en)
//   locked, delay             : search status and current reference tap
//   bit_cnt, err_cnt          : cumulative counts while locked, frozen together at bit_cnt saturation
//   win_errs, win_done        : error total of the last completed window and its one-cycle strobe
module ber_checker #(
    parameter int MAX_DLY  = 64,
    parameter int SYNC_WIN = 32,
    parameter int WIN_LEN  = 1024,
    parameter int LOSS_THR = 128,
    parameter int CNT_W    = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         bit_en,
    input  logic                         rx_bit,
    input  logic                         ref_bit,
    input  logic                         clear,
    output logic                         locked,
    output logic [$clog2(MAX_DLY)-1:0]   delay,
    output logic [CNT_W-1:0]             bit_cnt,
    output logic [CNT_W-1:0]             err_cnt,
    output logic [$clog2(WIN_LEN+1)-1:0] win_errs,
    output logic                         win_done
);

    localparam int DLY_W  = $clog2(MAX_DLY);
    localparam int WIN_W  = $clog2(WIN_LEN + 1);
    localparam int HUNT_W = $clog2(SYNC_WIN + 1);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_HUNT = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    state_t             state;
    logic [MAX_DLY-2:0] ref_dl;     // ref_dl[0] is the ref bit of the previous strobe
    logic [MAX_DLY-1:0] taps;       // tap 0 is the live ref_bit, so one fewer stored bit is needed
    logic [DLY_W-1:0]   fill_cnt;
    logic [HUNT_W-1:0]  hunt_cnt;
    logic [WIN_W-1:0]   win_bit;
    logic [WIN_W-1:0]   win_err;
    logic [WIN_W-1:0]   win_total;
    logic [DLY_W-1:0]   d_next;
    logic               tap_bit;
    logic               mism;

    assign taps      = {ref_dl, ref_bit};
    assign tap_bit   = taps[delay];
    assign mism      = rx_bit ^ tap_bit;
    // Window total including the bit being compared this cycle.
    assign win_total = win_err + WIN_W'(mism);
    assign d_next    = (delay == DLY_W'(MAX_DLY - 1)) ? '0 : delay + DLY_W'(1);

    // Search / lock state machine, window accounting and delay line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_FILL;
            ref_dl   <= '0;
            fill_cnt <= '0;
            hunt_cnt <= '0;
            win_bit  <= '0;
            win_err  <= '0;
            delay    <= '0;
            locked   <= 1'b0;
            win_errs <= '0;
            win_done <= 1'b0;
        end else begin
            win_done <= 1'b0;
            if (bit_en) begin
                ref_dl <= taps[MAX_DLY-2:0];
                case (state)
                    S_FILL: begin
                        // Wait until the delay line holds real reference history.
                        if (fill_cnt == DLY_W'(MAX_DLY - 1)) begin
                            state    <= S_HUNT;
                            delay    <= '0;
                            hunt_cnt <= '0;
                        end else begin
                            fill_cnt <= fill_cnt + DLY_W'(1);
                        end
                    end
                    S_HUNT: begin
                        if (mism) begin
                            delay    <= d_next;
                            hunt_cnt <= '0;
                        end else if (hunt_cnt == HUNT_W'(SYNC_WIN - 1)) begin
                            state    <= S_LOCK;
                            locked   <= 1'b1;
                            hunt_cnt <= '0;
                            win_bit  <= '0;
                            win_err  <= '0;
                        end else begin
                            hunt_cnt <= hunt_cnt + HUNT_W'(1);
                        end
                    end
                    S_LOCK: begin
                        if (win_bit == WIN_W'(WIN_LEN - 1)) begin
                            win_done <= 1'b1;
                            win_errs <= win_total;
                            win_bit  <= '0;
                            win_err  <= '0;
                            // A bad window means we are aligned to the wrong tap: resume the search
                            // one tap further on rather than retrying the tap that just failed.
                            if (32'(win_total) > 32'(LOSS_THR)) begin
                                state    <= S_HUNT;
                                locked   <= 1'b0;
                                delay    <= d_next;
                                hunt_cnt <= '0;
                            end
                        end else begin
                            win_bit <= win_bit + WIN_W'(1);
                            win_err <= win_total;
                        end
                    end
                    default: begin
                        state  <= S_FILL;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Cumulative counters. Once bit_cnt saturates both stop so err_cnt/bit_cnt stays a valid ratio.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt <= '0;
            err_cnt <= '0;
        end else if (clear) begin
            bit_cnt <= '0;
            err_cnt <= '0;
        end else if (bit_en && (state == S_LOCK) && (bit_cnt != '1)) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (mism && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ber_checker.sv
// Bench for ber_checker: period-15 m-sequence loopback with a 5-strobe rx delay, a 32-bit and an
// 8-bit counter instance on the same stimulus, a strobe-level reference model and literal checks.
module tb_ber_checker;

    localparam int MAX_DLY  = 64;
    localparam int SYNC_WIN = 32;
    localparam int WIN_LEN  = 1024;
    localparam int LOSS_THR = 128;
    localparam longint MAX32 = 64'hFFFF_FFFF;
    localparam longint MAX8  = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bit_en = 1'b0;
    logic        rx_bit = 1'b0;
    logic        ref_bit = 1'b0;
    logic        clear = 1'b0;

    logic        locked,   locked8;
    logic [5:0]  delay,    delay8;
    logic [31:0] bit_cnt,  err_cnt;
    logic [7:0]  bit_cnt8, err_cnt8;
    logic [10:0] win_errs, win_errs8;
    logic        win_done, win_done8;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    ber_checker dut (
        .clk(clk), .reset(reset), .bit_en(bit_en), .rx_bit(rx_bit), .ref_bit(ref_bit), .clear(clear),
        .locked(locked), .delay(delay), .bit_cnt(bit_cnt), .err_cnt(err_cnt),
        .win_errs(win_errs), .win_done(win_done)
    );

    ber_checker #(.CNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .bit_en(bit_en), .rx_bit(rx_bit), .ref_bit(ref_bit), .clear(clear),
        .locked(locked8), .delay(delay8), .bit_cnt(bit_cnt8), .err_cnt(err_cnt8),
        .win_errs(win_errs8), .win_done(win_done8)
    );

    always #5 clk = ~clk;

    // Stimulus source: a(n+4) = a(n+1) ^ a(n), period 15; rx is the ref stream 5 strobes late.
    logic [3:0]  lfsr    = 4'b0001;
    logic [63:0] tx_hist = '0;

    // ---------------- reference model (one step per accepted strobe) ----------------
    int     m_mode;             // 0 = filling, 1 = searching, 2 = locked
    int     m_d, m_fill, m_run, m_wb, m_we, m_werrs;
    bit     m_done;
    longint mb32, me32, mb8, me8;
    bit     m_ref[$];           // m_ref[k] = ref bit k+1 strobes ago

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode = 0; m_d = 0; m_fill = 0; m_run = 0; m_wb = 0; m_we = 0; m_werrs = 0;
            m_done = 1'b0; mb32 = 0; me32 = 0; mb8 = 0; me8 = 0;
            m_ref.delete();
        end else begin
            bit tap, mis, was_lock;
            m_done   = 1'b0;
            mis      = 1'b0;
            was_lock = (m_mode == 2);
            if (bit_en) begin
                if (m_d == 0)                tap = ref_bit;
                else if (m_d <= m_ref.size()) tap = m_ref[m_d-1];
                else                         tap = 1'b0;
                mis = (rx_bit != tap);
                if (m_mode == 0) begin
                    m_fill++;
                    if (m_fill == MAX_DLY) begin m_mode = 1; m_d = 0; m_run = 0; end
                end else if (m_mode == 1) begin
                    if (mis) begin
                        m_d = (m_d + 1) % MAX_DLY; m_run = 0;
                    end else begin
                        m_run++;
                        if (m_run == SYNC_WIN) begin m_mode = 2; m_wb = 0; m_we = 0; end
                    end
                end else begin
                    m_wb++;
                    m_we += int'(mis);
                    if (m_wb == WIN_LEN) begin
                        m_done = 1'b1; m_werrs = m_we; m_wb = 0; m_we = 0;
                        if (m_werrs > LOSS_THR) begin m_mode = 1; m_d = (m_d + 1) % MAX_DLY; m_run = 0; end
                    end
                end
                m_ref.push_front(ref_bit);
                if (m_ref.size() > MAX_DLY) m_ref.delete(MAX_DLY);
            end
            if (clear) begin
                mb32 = 0; me32 = 0; mb8 = 0; me8 = 0;
            end else if (bit_en && was_lock) begin
                if (mb32 < MAX32) begin mb32++; if (mis && me32 < MAX32) me32++; end
                if (mb8 < MAX8)   begin mb8++;  if (mis && me8 < MAX8)   me8++;  end
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            total++;
            if (locked !== (m_mode == 2) || delay !== 6'(m_d) || bit_cnt !== 32'(mb32) ||
                err_cnt !== 32'(me32) || win_errs !== 11'(m_werrs) || win_done !== m_done) begin
                bad++;
                $display("FAIL out32 t=%0t got lk=%0b d=%0d bc=%0d ec=%0d we=%0d wd=%0b want lk=%0b d=%0d bc=%0d ec=%0d we=%0d wd=%0b",
                         $time, locked, delay, bit_cnt, err_cnt, win_errs, win_done,
                         (m_mode == 2), m_d, mb32, me32, m_werrs, m_done);
            end
            total++;
            if (locked8 !== (m_mode == 2) || delay8 !== 6'(m_d) || bit_cnt8 !== 8'(mb8) ||
                err_cnt8 !== 8'(me8) || win_errs8 !== 11'(m_werrs) || win_done8 !== m_done) begin
                bad++;
                $display("FAIL out8 t=%0t got lk=%0b d=%0d bc=%0d ec=%0d we=%0d wd=%0b want lk=%0b d=%0d bc=%0d ec=%0d we=%0d wd=%0b",
                         $time, locked8, delay8, bit_cnt8, err_cnt8, win_errs8, win_done8,
                         (m_mode == 2), m_d, mb8, me8, m_werrs, m_done);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string nm, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, exp);
        end
    endtask

    // One strobe; returns #1 after the edge that registered it.
    task automatic strobe(input bit inv, input bit clr);
        @(negedge clk);
        bit_en  = 1'b1;
        ref_bit = lfsr[0];
        rx_bit  = tx_hist[4] ^ inv;
        clear   = clr;
        @(posedge clk);
        #1;
        tx_hist = {tx_hist[62:0], lfsr[0]};
        lfsr    = {lfsr[1] ^ lfsr[0], lfsr[3:1]};
    endtask

    task automatic idle(input bit clr);
        @(negedge clk);
        bit_en = 1'b0;
        clear  = clr;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        bit saw63;

        #3 reset = 1'b0;
        #1;
        check("reset_out32_zero", longint'(|{locked, delay, bit_cnt, err_cnt, win_errs, win_done}), 0);
        check("reset_out8_zero", longint'(|{locked8, delay8, bit_cnt8, err_cnt8, win_errs8, win_done8}), 0);
        chk_on = 1'b1;
        @(negedge clk);
        reset = 1'b1;

        // Initial acquisition, back-to-back strobes.
        n = 0;
        while (!locked && n < 400) begin strobe(0, 0); n++; end
        check("lock_within_256", longint'(n <= 256), 1);
        check("lock_delay", delay, 5);
        check("lock_bitcnt", bit_cnt, 0);

        // Two clean windows.
        for (int w = 0; w < 2; w++) begin
            n = 0;
            do begin strobe(0, 0); n++; end while (!win_done && n < 1100);
            check("win_period", n, 1024);
            check("win_errs_clean", win_errs, 0);
        end
        check("err_clean", err_cnt, 0);
        check("bitcnt_2win", bit_cnt, 2048);
        check("bitcnt8_sat", bit_cnt8, 255);
        check("errcnt8_clean", err_cnt8, 0);

        // Three flipped bits inside one window.
        for (int k = 0; k < WIN_LEN; k++) strobe(k == 10 || k == 200 || k == 700, 0);
        check("flip_win_done", win_done, 1);
        check("flip_win_errs", win_errs, 3);
        check("flip_err_cnt", err_cnt, 3);
        check("flip_locked", locked, 1);
        check("flip_errcnt8_frozen", err_cnt8, 0);
        check("flip_bitcnt8_frozen", bit_cnt8, 255);

        // clear alone, then clear together with a strobe.
        idle(1);
        check("clr_bitcnt", bit_cnt, 0);
        check("clr_errcnt", err_cnt, 0);
        check("clr_bitcnt8", bit_cnt8, 0);
        check("clr_locked", locked, 1);
        check("clr_win_errs", win_errs, 3);
        repeat (10) strobe(0, 0);
        check("resume_bitcnt", bit_cnt, 10);
        check("resume_bitcnt8", bit_cnt8, 10);
        strobe(0, 1);
        check("clr_strobe_bitcnt", bit_cnt, 0);
        repeat (5) strobe(0, 0);
        check("after_clr_bitcnt", bit_cnt, 5);
        n = 0;
        do begin strobe(0, 0); n++; end while (!win_done && n < 1100);
        check("win_counts_clr_bit", n, 1008);

        // Fully inverted window drops lock, then the search wraps and relocks.
        for (int k = 0; k < WIN_LEN; k++) strobe(1, 0);
        check("inv_win_done", win_done, 1);
        check("inv_win_errs", win_errs, 1024);
        check("inv_unlocked", locked, 0);
        check("inv_delay", delay, 6);
        saw63 = 1'b0;
        n = 0;
        while (delay != 0 && n < 3000) begin
            strobe(1, 0);
            if (delay == 63) saw63 = 1'b1;
            n++;
        end
        check("wrap_saw63", saw63, 1);
        check("wrap_delay0", delay, 0);
        n = 0;
        while (!locked && n < 600) begin strobe(0, 0); n++; end
        check("relock", locked, 1);
        check("relock_delay", delay, 5);

        // Asynchronous reset mid-lock, then sparse-strobe reacquisition.
        repeat (50) strobe(0, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_out32_zero", longint'(|{locked, delay, bit_cnt, err_cnt, win_errs, win_done}), 0);
        check("midrst_out8_zero", longint'(|{locked8, delay8, bit_cnt8, err_cnt8, win_errs8, win_done8}), 0);
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        while (!locked && n < 1500) begin strobe(0, 0); idle(0); idle(0); n++; end
        check("sparse_relock", locked, 1);
        check("sparse_relock_delay", delay, 5);
        n = 0;
        do begin
            strobe(0, 0);
            n++;
            if (win_done) break;
            idle(0);
            idle(0);
        end while (n < 1100);
        check("sparse_win_period", n, 1024);
        check("sparse_win_errs", win_errs, 0);
        idle(0);
        check("sparse_done_one_cycle", win_done, 0);

        repeat (2) idle(0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
